// File: rtl/adc_spi_responder_pkg.sv
// Shared ADC frame constants and FSM state encoding for the serial ADC responder.
// Reused by the ADC initiator and its assertions so both sides agree on frame layout.
package adc_spi_responder_pkg;

    localparam int unsigned DATA_W      = 12;  // sample width shifted out on DOUT
    localparam int unsigned FRAME_BITS  = 16;  // SCLK cycles per conversion frame
    localparam int unsigned LEAD_ZEROS  = 4;   // zero bits ahead of the sample MSB
    localparam int unsigned ADDR_W      = 3;   // channel address width
    localparam int unsigned ADDR_POS    = 2;   // rising-edge index of address MSB on DIN
    localparam int unsigned SYNC_STAGES = 2;   // synchronizer depth for the SPI inputs

    // Rising-edge counter saturates at FRAME_BITS, so it needs one value beyond the last index.
    localparam int unsigned CNT_W = $clog2(FRAME_BITS + 1);

    // Test-pattern sample is {channel, per-channel frame counter}.
    localparam int unsigned PAT_W = DATA_W - ADDR_W;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift
    } state_t;

endpackage

// File: rtl/adc_spi_responder_spi_in_sync.sv
// Synchronizes the asynchronous SPI inputs into the clk domain and detects edges.
// Ports:
//   clk, rst          system clock, asynchronous active-low reset
//   sclk_raw          serial clock from initiator
//   cs_n_raw          chip select from initiator (active low)
//   din_raw           serial control/address data from initiator
//   din_s             synchronized DIN, aligned with the SCLK edge pulses
//   sclk_rise/fall    one-cycle pulses on synchronized SCLK edges
//   cs_fall/cs_rise   one-cycle pulses on synchronized CS_N edges
module adc_spi_responder_spi_in_sync
    import adc_spi_responder_pkg::*;
#(
    parameter int unsigned STAGES = SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk_raw,
    input  logic cs_n_raw,
    input  logic din_raw,
    output logic din_s,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_fall,
    output logic cs_rise
);

    logic [STAGES-1:0] sclk_sync_q;
    logic [STAGES-1:0] cs_sync_q;
    logic [STAGES-1:0] din_sync_q;
    logic              sclk_prev_q;
    logic              cs_prev_q;

    // CS_N resets to its inactive level so reset release never looks like a frame start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            din_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[STAGES-2:0], sclk_raw};
            cs_sync_q   <= {cs_sync_q[STAGES-2:0], cs_n_raw};
            din_sync_q  <= {din_sync_q[STAGES-2:0], din_raw};
            sclk_prev_q <= sclk_sync_q[STAGES-1];
            cs_prev_q   <= cs_sync_q[STAGES-1];
        end
    end

    always_comb begin
        din_s     = din_sync_q[STAGES-1];
        sclk_rise = sclk_sync_q[STAGES-1] & ~sclk_prev_q;
        sclk_fall = ~sclk_sync_q[STAGES-1] & sclk_prev_q;
        cs_fall   = ~cs_sync_q[STAGES-1] & cs_prev_q;
        cs_rise   = cs_sync_q[STAGES-1] & ~cs_prev_q;
    end

endmodule

// File: rtl/adc_spi_responder.sv
// Slave-side model of the 8-channel 12-bit serial ADC. Decodes the channel address from DIN,
// requests a sample for the selected channel and shifts it out MSB-first after leading zeros.
// Optional feature macro ADC_RESP_TESTPAT_EN: ignore sample_data/sample_vld and load
// {sample_ch, per-channel frame counter} each frame instead; underrun never fires.
// Ports:
//   clk, rst                      system clock, asynchronous active-low reset
//   adc_sclk, adc_cs_n, adc_din   SPI inputs from the initiator
//   adc_dout                      serial sample data, updated after SCLK fall
//   sample_req, sample_ch         one-cycle sample request and the channel converted
//   sample_data, sample_vld       sample from the stimulus source
//   ch_addr                       committed channel address for the next frame
//   frame_done, underrun          one-cycle status pulses
module adc_spi_responder
    import adc_spi_responder_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              adc_sclk,
    input  logic              adc_cs_n,
    input  logic              adc_din,
    output logic              adc_dout,
    output logic              sample_req,
    output logic [ADDR_W-1:0] sample_ch,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              sample_vld,
    output logic [ADDR_W-1:0] ch_addr,
    output logic              frame_done,
    output logic              underrun
);

    localparam logic [CNT_W-1:0] CntFull   = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CntLead   = CNT_W'(LEAD_ZEROS);
    localparam logic [CNT_W-1:0] CntAddrLo = CNT_W'(ADDR_POS);
    localparam logic [CNT_W-1:0] CntAddrHi = CNT_W'(ADDR_POS + ADDR_W - 1);

    logic din_s, sclk_rise, sclk_fall, cs_fall, cs_rise;

    adc_spi_responder_spi_in_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst       (rst),
        .sclk_raw  (adc_sclk),
        .cs_n_raw  (adc_cs_n),
        .din_raw   (adc_din),
        .din_s     (din_s),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_fall   (cs_fall),
        .cs_rise   (cs_rise)
    );

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic                req_pend_q;
    logic [DATA_W-1:0]   shreg_q;
    logic [DATA_W-1:0]   shreg_src;
    logic [ADDR_W-1:0]   shadow_q;
    logic [ADDR_W-1:0]   sample_ch_q;
    logic [ADDR_W-1:0]   ch_addr_q;
    logic                dout_q;
    logic                sample_req_q;
    logic                frame_done_q;
    logic                underrun_q;
    logic                frame_end;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        frame_end = 1'b0;
        unique case (state_q)
            StIdle:  if (cs_fall) state_d = StLoad;
            // A CS_N pulse shorter than the sync window can rise while still in LOAD.
            StLoad:  state_d = cs_rise ? StIdle : StShift;
            StShift: begin
                if (cs_rise) begin
                    state_d   = StIdle;
                    frame_end = (bit_cnt_q == CntFull);
                end
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef ADC_RESP_TESTPAT_EN
    logic [PAT_W-1:0] pat_cnt_q [2**ADDR_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2**ADDR_W; i++) pat_cnt_q[i] <= '0;
        end else if (frame_end) begin
            pat_cnt_q[sample_ch_q] <= pat_cnt_q[sample_ch_q] + 1'b1;
        end
    end

    assign shreg_src = shreg_q;
`else
    // Sample arriving this cycle is usable immediately, including at the deadline edge.
    assign shreg_src = (req_pend_q && sample_vld) ? sample_data : shreg_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt_q    <= '0;
            req_pend_q   <= 1'b0;
            shreg_q      <= '0;
            shadow_q     <= '0;
            sample_ch_q  <= '0;
            ch_addr_q    <= '0;
            dout_q       <= 1'b0;
            sample_req_q <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            sample_req_q <= (state_q == StLoad) && !cs_rise;
            frame_done_q <= frame_end;
            underrun_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    dout_q     <= 1'b0;
                    req_pend_q <= 1'b0;
                end
                StLoad: begin
                    sample_ch_q <= ch_addr_q;
                    bit_cnt_q   <= '0;
                    shadow_q    <= '0;
                    dout_q      <= 1'b0;
`ifdef ADC_RESP_TESTPAT_EN
                    shreg_q     <= {ch_addr_q, pat_cnt_q[ch_addr_q]};
                    req_pend_q  <= 1'b0;
`else
                    shreg_q     <= '0;
                    req_pend_q  <= !cs_rise;
`endif
                end
                StShift: begin
                    if (cs_rise) begin
                        dout_q     <= 1'b0;
                        req_pend_q <= 1'b0;
                        if (frame_end) ch_addr_q <= shadow_q;
                    end else begin
                        if (req_pend_q && sample_vld) begin
                            shreg_q    <= shreg_src;
                            req_pend_q <= 1'b0;
                        end
                        if (sclk_rise) begin
                            if (bit_cnt_q < CntFull) bit_cnt_q <= bit_cnt_q + 1'b1;
                            if (bit_cnt_q >= CntAddrLo && bit_cnt_q <= CntAddrHi) begin
                                shadow_q <= {shadow_q[ADDR_W-2:0], din_s};
                            end
                        end
                        // On a fall, bit_cnt_q equals the index of the bit now presented.
                        if (sclk_fall && bit_cnt_q != '0) begin
                            if (bit_cnt_q < CntLead || bit_cnt_q >= CntFull) begin
                                dout_q <= 1'b0;
                            end else
`ifndef ADC_RESP_TESTPAT_EN
                            if (bit_cnt_q == CntLead && req_pend_q && !sample_vld) begin
                                underrun_q <= 1'b1;
                                req_pend_q <= 1'b0;
                                shreg_q    <= '0;
                                dout_q     <= 1'b0;
                            end else
`endif
                            begin
                                dout_q  <= shreg_src[DATA_W-1];
                                shreg_q <= {shreg_src[DATA_W-2:0], 1'b0};
                            end
                        end
                    end
                end
                default: dout_q <= 1'b0;
            endcase
        end
    end

    assign adc_dout   = dout_q;
    assign sample_req = sample_req_q;
    assign sample_ch  = sample_ch_q;
    assign ch_addr    = ch_addr_q;
    assign frame_done = frame_done_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Self-checking bench for adc_spi_responder: an SPI master drives frames, a background
// responder answers sample requests, and expected DOUT streams come from a frame-layout model.
module tb_adc_spi_responder;
    import adc_spi_responder_pkg::*;

    logic              clk;
    logic              rst;
    logic              adc_sclk;
    logic              adc_cs_n;
    logic              adc_din;
    logic              adc_dout;
    logic              sample_req;
    logic [ADDR_W-1:0] sample_ch;
    logic [DATA_W-1:0] sample_data;
    logic              sample_vld;
    logic [ADDR_W-1:0] ch_addr;
    logic              frame_done;
    logic              underrun;

    adc_spi_responder dut (
        .clk         (clk),
        .rst         (rst),
        .adc_sclk    (adc_sclk),
        .adc_cs_n    (adc_cs_n),
        .adc_din     (adc_din),
        .adc_dout    (adc_dout),
        .sample_req  (sample_req),
        .sample_ch   (sample_ch),
        .sample_data (sample_data),
        .sample_vld  (sample_vld),
        .ch_addr     (ch_addr),
        .frame_done  (frame_done),
        .underrun    (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Pulse monitors; tests look at deltas so this block is the only writer.
    int fd_cnt  = 0;
    int ur_cnt  = 0;
    int req_cnt = 0;
    logic [ADDR_W-1:0] req_ch = '0;

    always @(negedge clk) begin
        if (frame_done) fd_cnt++;
        if (underrun) ur_cnt++;
        if (sample_req) begin
            req_cnt++;
            req_ch = sample_ch;
        end
    end

    // Stimulus-source responder configuration.
    bit                resp_en    = 1'b0;
    int                resp_delay = 0;
    logic [DATA_W-1:0] resp_data  = '0;
    bit                resp_extra = 1'b0;
    int                junk_cnt   = 0;
    int                junk_done  = 0;

    initial begin
        sample_vld  = 1'b0;
        sample_data = '0;
        forever begin
            @(negedge clk);
            if (junk_cnt != junk_done) begin
                sample_data = DATA_W'($urandom);
                sample_vld  = 1'b1;
                @(negedge clk);
                sample_vld  = 1'b0;
                junk_done   = junk_cnt;
            end else if (sample_req && resp_en) begin
                repeat (resp_delay) @(negedge clk);
                sample_data = resp_data;
                sample_vld  = 1'b1;
                @(negedge clk);
                sample_vld  = 1'b0;
                sample_data = DATA_W'($urandom);
                if (resp_extra) begin
                    repeat (3) @(negedge clk);
                    sample_data = ~resp_data;
                    sample_vld  = 1'b1;
                    @(negedge clk);
                    sample_vld  = 1'b0;
                end
            end
        end
    end

    logic [ADDR_W-1:0] m_ch;  // model of the committed channel address

    // Expected DOUT for n rising edges; bit k of the frame sits at position 31-k.
    function automatic logic [31:0] exp_stream(input logic [DATA_W-1:0] s, input bit ur,
                                               input int n);
        logic [31:0] w;
        w = ur ? 32'h0 : (32'(s) << (32 - LEAD_ZEROS - DATA_W));
        if (n < 32) w = w & ~(32'hFFFF_FFFF >> n);
        return w;
    endfunction

    // DIN bits for a frame: random filler with the address placed MSB-first at ADDR_POS.
    function automatic logic [31:0] din_addr(input logic [ADDR_W-1:0] a, input logic [31:0] junk);
        logic [31:0] w;
        w = junk;
        for (int j = 0; j < int'(ADDR_W); j++) w[31 - int'(ADDR_POS) - j] = a[int'(ADDR_W) - 1 - j];
        return w;
    endfunction

    // Mode-0 master: DIN set while SCLK low, DOUT captured just before each rise.
    task automatic run_frame(input int n, input logic [31:0] din_bits, output logic [31:0] got,
                             output logic [ADDR_W-1:0] ch0, output bit ch_stable);
        got       = '0;
        ch0       = '0;
        ch_stable = 1'b1;
        adc_cs_n  = 1'b0;
        repeat (6) @(negedge clk);
        for (int k = 0; k < n; k++) begin
            adc_din = din_bits[31-k];
            repeat (5) @(negedge clk);
            got[31-k] = adc_dout;
            if (k == 0) ch0 = sample_ch;
            else if (sample_ch !== ch0) ch_stable = 1'b0;
            adc_sclk = 1'b1;
            repeat (5) @(negedge clk);
            adc_sclk = 1'b0;
        end
        repeat (5) @(negedge clk);
        adc_cs_n = 1'b1;
        adc_din  = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({adc_dout, sample_req, frame_done, underrun, sample_ch, ch_addr} !== '0)
            begin bad++; $display("FAIL reset_in: got %b want 0",
                {adc_dout, sample_req, frame_done, underrun, sample_ch, ch_addr}); end
        rst = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if ({adc_dout, sample_req, frame_done, underrun} !== 4'b0)
            begin bad++; $display("FAIL reset_flags: got %b want 0",
                {adc_dout, sample_req, frame_done, underrun}); end
        total++;
        if (ch_addr !== '0 || sample_ch !== '0)
            begin bad++; $display("FAIL reset_ch: got %0d/%0d want 0/0", ch_addr, sample_ch); end
        m_ch = '0;
    endtask

    task automatic test_basic();
        logic [31:0] got; logic [ADDR_W-1:0] ch0; bit st; int fd0, ur0, rq0;
        resp_en = 1'b1; resp_delay = 2; resp_data = 12'hA5C; resp_extra = 1'b0;
        fd0 = fd_cnt; ur0 = ur_cnt; rq0 = req_cnt;
        run_frame(16, din_addr(3'd0, 32'h0), got, ch0, st);
        total++;
        if (got !== exp_stream(12'hA5C, 1'b0, 16))
            begin bad++; $display("FAIL basic_dout: got %h want %h", got,
                exp_stream(12'hA5C, 1'b0, 16)); end
        total++;
        if (fd_cnt - fd0 != 1) begin bad++; $display("FAIL basic_done: got %0d want 1", fd_cnt - fd0); end
        total++;
        if (ur_cnt - ur0 != 0) begin bad++; $display("FAIL basic_underrun: got %0d want 0", ur_cnt - ur0); end
        total++;
        if (req_cnt - rq0 != 1) begin bad++; $display("FAIL basic_req: got %0d want 1", req_cnt - rq0); end
        total++;
        if (adc_dout !== 1'b0) begin bad++; $display("FAIL basic_idle_dout: got %b want 0", adc_dout); end
    endtask

    task automatic test_addr();
        logic [31:0] got; logic [ADDR_W-1:0] ch0; bit st; logic [DATA_W-1:0] s;
        s = DATA_W'($urandom); resp_delay = $urandom_range(0, 20); resp_data = s;
        run_frame(16, din_addr(3'd5, $urandom), got, ch0, st);
        m_ch = 3'd5;
        total++;
        if (ch_addr !== m_ch) begin bad++; $display("FAIL addr_commit: got %0d want %0d", ch_addr, m_ch); end
        s = DATA_W'($urandom); resp_data = s;
        run_frame(16, din_addr(3'd0, $urandom), got, ch0, st);
        total++;
        if (req_ch !== 3'd5 || ch0 !== 3'd5 || !st)
            begin bad++; $display("FAIL addr_sample_ch: got req=%0d first=%0d stable=%0d want 5/5/1",
                req_ch, ch0, st); end
        total++;
        if (got !== exp_stream(s, 1'b0, 16))
            begin bad++; $display("FAIL addr_dout: got %h want %h", got, exp_stream(s, 1'b0, 16)); end
        m_ch = 3'd0;
        total++;
        if (ch_addr !== m_ch) begin bad++; $display("FAIL addr_commit2: got %0d want %0d", ch_addr, m_ch); end
    endtask

    task automatic test_underrun();
        logic [31:0] got; logic [ADDR_W-1:0] ch0; bit st; int fd0, ur0;
        resp_delay = 60; resp_data = 12'hFFF;
        fd0 = fd_cnt; ur0 = ur_cnt;
        run_frame(16, din_addr(m_ch, 32'h0), got, ch0, st);
        total++;
        if (ur_cnt - ur0 != 1) begin bad++; $display("FAIL underrun_pulse: got %0d want 1", ur_cnt - ur0); end
        total++;
        if (got !== exp_stream(12'hFFF, 1'b1, 16))
            begin bad++; $display("FAIL underrun_dout: got %h want %h", got, exp_stream(12'hFFF, 1'b1, 16)); end
        total++;
        if (fd_cnt - fd0 != 1) begin bad++; $display("FAIL underrun_done: got %0d want 1", fd_cnt - fd0); end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_abort();
        logic [31:0] got; logic [ADDR_W-1:0] ch0; bit st; int fd0, ur0; logic [DATA_W-1:0] s;
        resp_delay = 2; resp_data = 12'hFFF;
        fd0 = fd_cnt;
        run_frame(9, din_addr(3'd3, $urandom), got, ch0, st);
        total++;
        if (fd_cnt - fd0 != 0) begin bad++; $display("FAIL abort_done: got %0d want 0", fd_cnt - fd0); end
        total++;
        if (ch_addr !== m_ch) begin bad++; $display("FAIL abort_ch: got %0d want %0d", ch_addr, m_ch); end
        total++;
        if (adc_dout !== 1'b0) begin bad++; $display("FAIL abort_dout_idle: got %b want 0", adc_dout); end
        total++;
        if (got !== exp_stream(12'hFFF, 1'b0, 9))
            begin bad++; $display("FAIL abort_bits: got %h want %h", got, exp_stream(12'hFFF, 1'b0, 9)); end
        // Abort with a request still outstanding; its late answer lands in IDLE.
        resp_delay = 60;
        run_frame(2, din_addr(3'd3, 32'h0), got, ch0, st);
        repeat (80) @(negedge clk);
        s = DATA_W'($urandom); resp_delay = 5; resp_data = s;
        fd0 = fd_cnt; ur0 = ur_cnt;
        run_frame(16, din_addr(m_ch, 32'h0), got, ch0, st);
        total++;
        if (got !== exp_stream(s, 1'b0, 16) || ur_cnt - ur0 != 0 || fd_cnt - fd0 != 1)
            begin bad++; $display("FAIL abort_recover: got %h ur=%0d fd=%0d want %h ur=0 fd=1",
                got, ur_cnt - ur0, fd_cnt - fd0, exp_stream(s, 1'b0, 16)); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got; logic [ADDR_W-1:0] ch0; bit st; int fd0;
        resp_delay = 3; resp_data = DATA_W'($urandom);
        run_frame(16, din_addr(3'd6, $urandom), got, ch0, st);
        m_ch = 3'd6;
        resp_delay = 2; resp_data = 12'hFFF;
        adc_cs_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int k = 0; k < 7; k++) begin
            adc_din = 1'b1;
            repeat (5) @(negedge clk);
            adc_sclk = 1'b1;
            repeat (5) @(negedge clk);
            adc_sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
        total++;
        if (adc_dout !== 1'b1 || sample_ch !== 3'd6 || ch_addr !== 3'd6)
            begin bad++; $display("FAIL midrst_pre: got dout=%b ch=%0d addr=%0d want 1/6/6",
                adc_dout, sample_ch, ch_addr); end
        rst = 1'b0;
        #1;
        total++;
        if ({adc_dout, sample_req, frame_done, underrun, sample_ch, ch_addr} !== '0)
            begin bad++; $display("FAIL midrst_outputs: got %b want 0",
                {adc_dout, sample_req, frame_done, underrun, sample_ch, ch_addr}); end
        adc_cs_n = 1'b1; adc_sclk = 1'b0; adc_din = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        m_ch = 3'd0;
        resp_delay = $urandom_range(0, 20); resp_data = 12'h123;
        fd0 = fd_cnt;
        run_frame(16, din_addr(3'd0, 32'h0), got, ch0, st);
        total++;
        if (got !== exp_stream(12'h123, 1'b0, 16) || req_ch !== 3'd0 || fd_cnt - fd0 != 1)
            begin bad++; $display("FAIL midrst_next: got %h ch=%0d fd=%0d want %h ch=0 fd=1",
                got, req_ch, fd_cnt - fd0, exp_stream(12'h123, 1'b0, 16)); end
    endtask

    task automatic test_extra_sclk();
        logic [31:0] got; logic [ADDR_W-1:0] ch0; bit st; int fd0; logic [DATA_W-1:0] s;
        logic [ADDR_W-1:0] a;
        s = DATA_W'($urandom); a = ADDR_W'($urandom); resp_delay = 4; resp_data = s;
        fd0 = fd_cnt;
        run_frame(20, din_addr(a, $urandom), got, ch0, st);
        m_ch = a;
        total++;
        if (got !== exp_stream(s, 1'b0, 20))
            begin bad++; $display("FAIL extra_dout: got %h want %h", got, exp_stream(s, 1'b0, 20)); end
        total++;
        if (fd_cnt - fd0 != 1 || ch_addr !== m_ch)
            begin bad++; $display("FAIL extra_done: got fd=%0d ch=%0d want 1/%0d",
                fd_cnt - fd0, ch_addr, m_ch); end
    endtask

    task automatic test_random();
        logic [31:0] got; logic [ADDR_W-1:0] ch0; bit st; int fd0, ur0; logic [DATA_W-1:0] s;
        logic [ADDR_W-1:0] a; bit late;
        for (int it = 0; it < 8; it++) begin
            s = DATA_W'($urandom); a = ADDR_W'($urandom);
            late = ($urandom_range(0, 3) == 0);
            resp_delay = late ? $urandom_range(55, 70) : $urandom_range(0, 30);
            resp_data = s; resp_extra = 1'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                junk_cnt++;
                repeat (4) @(negedge clk);
            end
            fd0 = fd_cnt; ur0 = ur_cnt;
            run_frame(16, din_addr(a, $urandom), got, ch0, st);
            total++;
            if (got !== exp_stream(s, late, 16) || ur_cnt - ur0 != int'(late))
                begin bad++; $display("FAIL rand_dout[%0d]: got %h ur=%0d want %h ur=%0d",
                    it, got, ur_cnt - ur0, exp_stream(s, late, 16), late); end
            total++;
            if (req_ch !== m_ch || !st)
                begin bad++; $display("FAIL rand_sample_ch[%0d]: got %0d stable=%0d want %0d",
                    it, req_ch, st, m_ch); end
            m_ch = a;
            total++;
            if (ch_addr !== m_ch || fd_cnt - fd0 != 1)
                begin bad++; $display("FAIL rand_commit[%0d]: got ch=%0d fd=%0d want %0d/1",
                    it, ch_addr, fd_cnt - fd0, m_ch); end
            repeat (60) @(negedge clk);
        end
        resp_extra = 1'b0;
    endtask

`ifdef ADC_RESP_TESTPAT_EN
    task automatic test_testpat();
        logic [31:0] got; logic [ADDR_W-1:0] ch0; bit st; int ur0; logic [DATA_W-1:0] s;
        int pc [2**ADDR_W];
        for (int i = 0; i < 2**ADDR_W; i++) pc[i] = 0;
        resp_en = 1'b0;
        for (int f = 0; f < 4; f++) begin
            s = DATA_W'((int'(m_ch) << PAT_W) | pc[m_ch]);
            ur0 = ur_cnt;
            run_frame(16, din_addr(3'd2, $urandom), got, ch0, st);
            total++;
            if (got !== exp_stream(s, 1'b0, 16) || ur_cnt - ur0 != 0)
                begin bad++; $display("FAIL testpat[%0d]: got %h ur=%0d want %h ur=0",
                    f, got, ur_cnt - ur0, exp_stream(s, 1'b0, 16)); end
            pc[m_ch] = (pc[m_ch] + 1) % (2**PAT_W);
            m_ch = 3'd2;
        end
    endtask
`endif

    initial begin
        rst = 1'b0; adc_sclk = 1'b0; adc_cs_n = 1'b1; adc_din = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
`ifdef ADC_RESP_TESTPAT_EN
        test_testpat();
`else
        test_basic();
        test_addr();
        test_underrun();
        test_abort();
        test_reset_mid();
        test_extra_sclk();
        test_random();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
